// File: rtl/jump_ctrl_pkg.sv
// Shared definitions for the jump controller: opcodes, flag bit positions
// and the default interrupt entry address.
package jump_ctrl_pkg;

  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_JZ  = 6'b011100;
  localparam logic [5:0] OP_JNZ = 6'b011110;
  localparam logic [5:0] OP_JV  = 6'b011101;
  localparam logic [5:0] OP_JNV = 6'b011111;
  localparam logic [5:0] OP_RET = 6'b010000;

  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [15:0] INT_VECTOR_DEFAULT = 16'hF000;

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational jump decode: flags whether op is a jump and whether its
// condition holds against the execute-stage flags.
module jump_cond_eval
  import jump_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [1:0] flag_ex,
  output logic       is_jump,
  output logic       taken
);

  logic flag_z;
  logic flag_v;

  assign flag_z = flag_ex[FLAG_Z];
  assign flag_v = flag_ex[FLAG_V];

  always_comb begin
    is_jump = 1'b1;
    taken   = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = flag_z;
      OP_JNZ:  taken = ~flag_z;
      OP_JV:   taken = flag_v;
      OP_JNV:  taken = ~flag_v;
      default: is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/jump_control.sv
// PC redirect controller: taken jumps, interrupt entry and return from interrupt.
// Interrupt support (edge detect, saved return address, RET) exists only with JUMP_CTRL_INT_EN.
module jump_control
  import jump_ctrl_pkg::*;
#(
  parameter logic [15:0] INT_VECTOR = INT_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] jmp_address_pm,
  input  logic [15:0] current_address,
  input  logic [5:0]  op,
  input  logic [1:0]  flag_ex,
  input  logic        interrupt,
  output logic [15:0] jmp_loc,
  output logic        pc_mux_sel
);

  logic        is_jump;
  logic        taken;
  logic        int_event;
  logic        ret_sel;
  logic [15:0] ret_addr;

  jump_cond_eval u_cond (
    .op      (op),
    .flag_ex (flag_ex),
    .is_jump (is_jump),
    .taken   (taken)
  );

`ifdef JUMP_CTRL_INT_EN
  logic        int_dly_d;
  logic        int_dly_q;
  logic [15:0] ret_addr_d;
  logic [15:0] ret_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_dly_q  <= 1'b0;
      ret_addr_q <= '0;
    end else begin
      int_dly_q  <= int_dly_d;
      ret_addr_q <= ret_addr_d;
    end
  end

  // An interrupt wins over any jump/RET in the same cycle, so the
  // sequential address of that cycle is what must be returned to.
  always_comb begin
    int_dly_d  = interrupt;
    int_event  = interrupt & ~int_dly_q;
    ret_sel    = (op == OP_RET);
    ret_addr_d = int_event ? current_address : ret_addr_q;
  end

  assign ret_addr = ret_addr_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{interrupt, current_address, clk};
  assign int_event     = 1'b0;
  assign ret_sel       = 1'b0;
  assign ret_addr      = '0;
`endif

  always_comb begin
    pc_mux_sel = 1'b0;
    jmp_loc    = jmp_address_pm;
    if (!reset) begin
      jmp_loc = '0;
    end else if (int_event) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = INT_VECTOR;
    end else if (ret_sel) begin
      pc_mux_sel = 1'b1;
      jmp_loc    = ret_addr;
    end else if (is_jump && taken) begin
      pc_mux_sel = 1'b1;
    end
  end

endmodule

// File: tb/tb_jump_control.sv
// Self-checking bench for jump_control; expectations follow the build
// (JUMP_CTRL_INT_EN defined or not).
module tb_jump_control;

  localparam logic [15:0] VEC = 16'hF000;
`ifdef JUMP_CTRL_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] jmp_address_pm = '0;
  logic [15:0] current_address = '0;
  logic [5:0]  op = '0;
  logic [1:0]  flag_ex = '0;
  logic        interrupt = 1'b0;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel;

  always #5 clk = ~clk;

  jump_control #(.INT_VECTOR(VEC)) dut (
    .clk             (clk),
    .reset           (reset),
    .jmp_address_pm  (jmp_address_pm),
    .current_address (current_address),
    .op              (op),
    .flag_ex         (flag_ex),
    .interrupt       (interrupt),
    .jmp_loc         (jmp_loc),
    .pc_mux_sel      (pc_mux_sel)
  );

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  flag;
    logic [15:0] jaddr;
    logic        exp_sel;
    logic [15:0] exp_loc;
    string       name;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [15:0] loc;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        m_int_d = 1'b0;
  logic [15:0] m_ret = '0;
  vec_t        tab[12];

  function automatic bit ref_taken(input logic [5:0] o, input logic [1:0] f);
    case (o)
      6'b011000: return 1'b1;
      6'b011100: return f[1];
      6'b011110: return !f[1];
      6'b011101: return f[0];
      6'b011111: return !f[0];
      default:   return 1'b0;
    endcase
  endfunction

  function automatic exp_t model_exp(input string nm);
    exp_t e;
    e.name = nm;
    e.sel  = 1'b0;
    e.loc  = jmp_address_pm;
    if (!reset) begin
      e.loc = 16'h0000;
    end else if (INT_EN && interrupt && !m_int_d) begin
      e.sel = 1'b1;
      e.loc = VEC;
    end else if (INT_EN && op == 6'b010000) begin
      e.sel = 1'b1;
      e.loc = m_ret;
    end else if (ref_taken(op, flag_ex)) begin
      e.sel = 1'b1;
    end
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (pc_mux_sel !== e.sel || jmp_loc !== e.loc) begin
        errors++;
        $display("FAIL %s: got sel=%b loc=%h, want sel=%b loc=%h",
                 e.name, pc_mux_sel, jmp_loc, e.sel, e.loc);
      end
    end
  endtask

  // Queue the expectation, sample mid-cycle, then clock and advance the model.
  task automatic step(input string nm, input bit use_tab,
                      input logic tsel, input logic [15:0] tloc);
    exp_t e;
    e = model_exp(nm);
    if (use_tab) begin
      e.sel = tsel;
      e.loc = tloc;
    end
    sb_q.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    if (reset) begin
      if (INT_EN && interrupt && !m_int_d) m_ret = current_address;
      m_int_d = INT_EN ? interrupt : 1'b0;
    end
    #1;
  endtask

  task automatic set_reset(input logic val);
    reset = val;
    if (!val) begin
      m_int_d = 1'b0;
      m_ret   = '0;
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [1:0] f, input logic [15:0] ja,
                       input logic [15:0] ca, input logic irq);
    op = o; flag_ex = f; jmp_address_pm = ja; current_address = ca; interrupt = irq;
  endtask

  initial begin
    tab[0]  = '{6'b011000, 2'b00, 16'h0008, 1'b1, 16'h0008, "jmp"};
    tab[1]  = '{6'b011110, 2'b00, 16'h0008, 1'b1, 16'h0008, "jnz_z0"};
    tab[2]  = '{6'b011110, 2'b10, 16'h0008, 1'b0, 16'h0008, "jnz_z1"};
    tab[3]  = '{6'b011100, 2'b10, 16'h1234, 1'b1, 16'h1234, "jz_z1"};
    tab[4]  = '{6'b011100, 2'b00, 16'h1234, 1'b0, 16'h1234, "jz_z0"};
    tab[5]  = '{6'b011101, 2'b01, 16'hABCD, 1'b1, 16'hABCD, "jv_v1"};
    tab[6]  = '{6'b011101, 2'b10, 16'hABCD, 1'b0, 16'hABCD, "jv_v0"};
    tab[7]  = '{6'b011111, 2'b10, 16'hFFFF, 1'b1, 16'hFFFF, "jnv_v0"};
    tab[8]  = '{6'b011111, 2'b01, 16'hFFFF, 1'b0, 16'hFFFF, "jnv_v1"};
    tab[9]  = '{6'b011100, 2'b01, 16'h0F0F, 1'b0, 16'h0F0F, "jz_vonly"};
    tab[10] = '{6'b011001, 2'b11, 16'h5555, 1'b0, 16'h5555, "op_near_jmp"};
    tab[11] = '{6'b111000, 2'b00, 16'hAAAA, 1'b0, 16'hAAAA, "op_other"};

    // Reset held: outputs forced even with a jump and interrupt present.
    set_reset(1'b0);
    drive(6'b000000, 2'b00, 16'h0000, 16'h0001, 1'b0);
    #2;
    step("rst_hold", 1'b1, 1'b0, 16'h0000);
    drive(6'b011000, 2'b00, 16'h0008, 16'h0001, 1'b1);
    step("rst_forced", 1'b1, 1'b0, 16'h0000);

    set_reset(1'b1);
    drive(6'b000000, 2'b00, 16'h0000, 16'h0001, 1'b0);
    step("post_rst", 1'b1, 1'b0, 16'h0000);

    // RET with nothing saved returns to 0 (or is a no-op without interrupts).
    drive(6'b010000, 2'b00, 16'h3333, 16'h0002, 1'b0);
    step("ret_no_int", 1'b0, 1'b0, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      drive(tab[i].op, tab[i].flag, tab[i].jaddr, 16'h0100 + 16'(i), 1'b0);
      step(tab[i].name, 1'b1, tab[i].exp_sel, tab[i].exp_loc);
    end

    // Rising interrupt: one-cycle redirect, then held level is ignored.
    drive(6'b000000, 2'b00, 16'h0000, 16'h0001, 1'b1);
    step("int_entry", 1'b0, 1'b0, 16'h0000);
    drive(6'b000000, 2'b00, 16'h0000, 16'h0002, 1'b1);
    step("int_held", 1'b0, 1'b0, 16'h0000);
    step("int_held2", 1'b0, 1'b0, 16'h0000);
    drive(6'b010000, 2'b00, 16'h0000, 16'h0003, 1'b0);
    step("ret_0001", 1'b0, 1'b0, 16'h0000);

    // Interrupt preempts a jump; return address is that cycle's sequential PC.
    drive(6'b011000, 2'b00, 16'h0008, 16'h0042, 1'b1);
    step("int_vs_jmp", 1'b0, 1'b0, 16'h0000);
    drive(6'b010000, 2'b00, 16'h0008, 16'h0050, 1'b1);
    step("ret_0042", 1'b0, 1'b0, 16'h0000);

    // Interrupt preempts a RET.
    drive(6'b010000, 2'b00, 16'h0008, 16'h0060, 1'b0);
    step("int_low", 1'b0, 1'b0, 16'h0000);
    drive(6'b010000, 2'b00, 16'h0008, 16'h0070, 1'b1);
    step("int_vs_ret", 1'b0, 1'b0, 16'h0000);
    drive(6'b010000, 2'b00, 16'h0008, 16'h0071, 1'b0);
    step("ret_0070", 1'b0, 1'b0, 16'h0000);

    // Mid-interrupt reset clears the saved address.
    drive(6'b000000, 2'b00, 16'h0000, 16'h0777, 1'b1);
    step("int_pre_rst", 1'b0, 1'b0, 16'h0000);
    set_reset(1'b0);
    #1;
    step("rst_async", 1'b1, 1'b0, 16'h0000);
    drive(6'b010000, 2'b00, 16'h0000, 16'h0778, 1'b0);
    set_reset(1'b1);
    step("ret_after_rst", 1'b0, 1'b0, 16'h0000);

    // Interrupt already high at reset release counts as an event.
    set_reset(1'b0);
    drive(6'b000000, 2'b00, 16'h0000, 16'h0900, 1'b1);
    step("rst_int_high", 1'b1, 1'b0, 16'h0000);
    set_reset(1'b1);
    step("int_at_release", 1'b0, 1'b0, 16'h0000);
    drive(6'b010000, 2'b00, 16'h0000, 16'h0901, 1'b1);
    step("ret_0900", 1'b0, 1'b0, 16'h0000);

    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1);
  end

endmodule
